// File: rtl/spi_txn_queue_if.sv
// Host and SPI-master signal bundle for spi_txn_queue.
// The slave modport is the queue's view; the master modport is the host/SPI-master side.
interface spi_txn_queue_if #(
  parameter int CW = 4
);
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          tx_full;
  logic          rd_en;
  logic [7:0]    rd_data;
  logic          rx_empty;
  logic [CW-1:0] tx_count;
  logic [CW-1:0] rx_count;
  logic          run;
  logic          clr_err;
  logic          ovf_err;
  logic          unf_err;
  logic          tmo_err;
  logic          busy;
  logic [7:0]    m_data_in;
  logic          m_start;
  logic [7:0]    m_data_out;
  logic          m_done;

  modport slave (
    input  wr_en, wr_data, rd_en, run, clr_err, m_data_out, m_done,
    output tx_full, rd_data, rx_empty, tx_count, rx_count,
           ovf_err, unf_err, tmo_err, busy, m_data_in, m_start
  );

  modport master (
    output wr_en, wr_data, rd_en, run, clr_err, m_data_out, m_done,
    input  tx_full, rd_data, rx_empty, tx_count, rx_count,
           ovf_err, unf_err, tmo_err, busy, m_data_in, m_start
  );
endinterface

// File: rtl/spi_txn_queue.sv
// TX/RX byte queues around an SPI master: pops TX bytes, launches a transfer,
// and stores the returned byte in the RX queue, with timeout and sticky errors.
//
// state    | meaning
// S_IDLE   | waiting for run, a TX byte and guaranteed RX space
// S_LAUNCH | pop TX head into hold register, pulse m_start, arm timer
// S_WAIT   | wait for m_done rising edge or timer terminal count
module spi_txn_queue #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_txn_queue_if.slave    bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          done_d;
  logic [7:0]    hold_q;

  logic [7:0]    tx_mem [DEPTH];
  logic [7:0]    rx_mem [DEPTH];
  logic [CW-1:0] tx_wptr, tx_rptr, rx_wptr, rx_rptr;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic          tx_full, rx_empty;
  logic          push_ok, tx_pop, rx_wr, rx_pop, tmo_hit, done_rise, inflight, rx_room;
  logic          ovf_q, unf_q, tmo_q;

  // Pointers carry one extra wrap bit so the difference is the occupancy.
  assign tx_cnt   = tx_wptr - tx_rptr;
  assign rx_cnt   = rx_wptr - rx_rptr;
  assign tx_full  = (tx_cnt == CW'(DEPTH));
  assign rx_empty = (rx_cnt == '0);

  assign push_ok   = bus.wr_en & ~tx_full;
  assign rx_pop    = bus.rd_en & ~rx_empty;
  assign tx_pop    = (state_q == S_LAUNCH);
  assign done_rise = bus.m_done & ~done_d;
  assign inflight  = (state_q != S_IDLE);
  assign rx_room   = (({1'b0, rx_cnt} + {{CW{1'b0}}, inflight}) < (CW+1)'(DEPTH));

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    rx_wr   = 1'b0;
    tmo_hit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.run && (tx_cnt != '0) && rx_room) state_d = S_LAUNCH;
      end
      S_LAUNCH: begin
        tmr_d   = TW'(TIMEOUT);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (done_rise) begin
          rx_wr   = 1'b1;
          state_d = S_IDLE;
        end else if (tmr_q == TW'(1)) begin
          tmo_hit = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      done_d  <= 1'b0;
      hold_q  <= 8'h00;
      tx_wptr <= '0;
      tx_rptr <= '0;
      rx_wptr <= '0;
      rx_rptr <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      done_d  <= bus.m_done;
      if (tx_pop) hold_q <= tx_mem[tx_rptr[AW-1:0]];
      if (push_ok) tx_wptr <= tx_wptr + CW'(1);
      if (tx_pop)  tx_rptr <= tx_rptr + CW'(1);
      if (rx_wr)   rx_wptr <= rx_wptr + CW'(1);
      if (rx_pop)  rx_rptr <= rx_rptr + CW'(1);
      // A new error event wins over a same-cycle clear.
      ovf_q <= (bus.wr_en & tx_full)  | (ovf_q & ~bus.clr_err);
      unf_q <= (bus.rd_en & rx_empty) | (unf_q & ~bus.clr_err);
      tmo_q <= tmo_hit                | (tmo_q & ~bus.clr_err);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) tx_mem[tx_wptr[AW-1:0]] <= bus.wr_data;
    if (rx_wr)   rx_mem[rx_wptr[AW-1:0]] <= bus.m_data_out;
  end

  // During LAUNCH the head is shown directly so m_data_in is valid with m_start.
  assign bus.m_data_in = (state_q == S_LAUNCH) ? tx_mem[tx_rptr[AW-1:0]] : hold_q;
  assign bus.m_start   = (state_q == S_LAUNCH);
  assign bus.busy      = inflight;
  assign bus.tx_full   = tx_full;
  assign bus.rx_empty  = rx_empty;
  assign bus.tx_count  = tx_cnt;
  assign bus.rx_count  = rx_cnt;
  assign bus.rd_data   = rx_mem[rx_rptr[AW-1:0]];
  assign bus.ovf_err   = ovf_q;
  assign bus.unf_err   = unf_q;
  assign bus.tmo_err   = tmo_q;
endmodule

// File: tb/tb_spi_txn_queue.sv
// Directed bench for spi_txn_queue with DEPTH=8, TIMEOUT=64.
module tb_spi_txn_queue;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 64;
  localparam int CW      = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  spi_txn_queue_if #(.CW(CW)) bus ();

  spi_txn_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.m_start) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic respond(input logic [7:0] resp);
    tick();
    bus.m_data_out = resp;
    bus.m_done     = 1'b1;
    tick();
    bus.m_done     = 1'b0;
  endtask

  task automatic test_reset;
    bus.wr_en = 0; bus.wr_data = 0; bus.rd_en = 0; bus.run = 0;
    bus.clr_err = 0; bus.m_data_out = 0; bus.m_done = 0;
    rst_n = 1'b0;
    #12;
    checks++; if (bus.tx_full !== 1'b0) begin errors++; $display("FAIL reset_tx_full: got %b want 0", bus.tx_full); end
    checks++; if (bus.rx_empty !== 1'b1) begin errors++; $display("FAIL reset_rx_empty: got %b want 1", bus.rx_empty); end
    checks++; if (bus.tx_count !== 4'd0 || bus.rx_count !== 4'd0) begin errors++; $display("FAIL reset_counts: got tx=%0d rx=%0d want 0 0", bus.tx_count, bus.rx_count); end
    checks++; if (bus.busy !== 1'b0 || bus.m_start !== 1'b0) begin errors++; $display("FAIL reset_fsm: got busy=%b start=%b want 0 0", bus.busy, bus.m_start); end
    checks++; if (bus.m_data_in !== 8'h00) begin errors++; $display("FAIL reset_m_data_in: got %h want 00", bus.m_data_in); end
    checks++; if ({bus.ovf_err, bus.unf_err, bus.tmo_err} !== 3'b000) begin errors++; $display("FAIL reset_errs: got %b want 000", {bus.ovf_err, bus.unf_err, bus.tmo_err}); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single;
    bit ok;
    bus.wr_data = 8'hA5; bus.wr_en = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    checks++; if (bus.tx_count !== 4'd1) begin errors++; $display("FAIL single_push_count: got %0d want 1", bus.tx_count); end
    bus.run = 1'b1;
    wait_start(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_start_seen: got %b want 1", ok); end
    checks++; if (bus.m_data_in !== 8'hA5) begin errors++; $display("FAIL single_m_data_in: got %h want a5", bus.m_data_in); end
    bus.run = 1'b0;
    tick();
    checks++; if (bus.m_start !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL single_wait_state: got start=%b busy=%b want 0 1", bus.m_start, bus.busy); end
    checks++; if (bus.m_data_in !== 8'hA5) begin errors++; $display("FAIL single_hold_stable: got %h want a5", bus.m_data_in); end
    bus.m_data_out = 8'h3C; bus.m_done = 1'b1;
    tick();
    bus.m_done = 1'b0;
    checks++; if (bus.rx_count !== 4'd1 || bus.rd_data !== 8'h3C) begin errors++; $display("FAIL single_result: got cnt=%0d data=%h want 1 3c", bus.rx_count, bus.rd_data); end
    checks++; if (bus.busy !== 1'b0 || bus.tx_count !== 4'd0) begin errors++; $display("FAIL single_idle: got busy=%b tx=%0d want 0 0", bus.busy, bus.tx_count); end
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    checks++; if (bus.rx_count !== 4'd0 || bus.unf_err !== 1'b0) begin errors++; $display("FAIL single_pop: got cnt=%0d unf=%b want 0 0", bus.rx_count, bus.unf_err); end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 9; i++) begin
      bus.wr_data = 8'h10 + 8'(i); bus.wr_en = 1'b1;
      tick();
      if (i == 7) begin
        checks++; if (bus.tx_full !== 1'b1 || bus.tx_count !== 4'd8) begin errors++; $display("FAIL ovf_full_at_8: got full=%b cnt=%0d want 1 8", bus.tx_full, bus.tx_count); end
        checks++; if (bus.ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_not_early: got %b want 0", bus.ovf_err); end
      end
    end
    bus.wr_en = 1'b0;
    checks++; if (bus.ovf_err !== 1'b1 || bus.tx_count !== 4'd8) begin errors++; $display("FAIL ovf_ninth: got ovf=%b cnt=%0d want 1 8", bus.ovf_err, bus.tx_count); end
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    checks++; if (bus.ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", bus.ovf_err); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    bit seen;
    int last;
    last = 0;
    bus.run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_start(ok);
      checks++; if (ok !== 1'b1 || bus.m_data_in !== 8'h10 + 8'(i)) begin errors++; $display("FAIL b2b_launch_%0d: got ok=%b data=%h want 1 %h", i, ok, bus.m_data_in, 8'h10 + 8'(i)); end
      if (i > 0) begin
        checks++; if (cyc - last !== 3) begin errors++; $display("FAIL b2b_spacing_%0d: got %0d want 3", i, cyc - last); end
      end
      last = cyc;
      respond(8'hC0 + 8'(i));
    end
    checks++; if (bus.rx_count !== 4'd8 || bus.tx_count !== 4'd0) begin errors++; $display("FAIL b2b_after_fill: got rx=%0d tx=%0d want 8 0", bus.rx_count, bus.tx_count); end
    bus.wr_en = 1'b1; bus.wr_data = 8'hE1;
    tick();
    bus.wr_data = 8'hE2;
    tick();
    bus.wr_en = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.m_start) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0 || bus.tx_count !== 4'd2) begin errors++; $display("FAIL rxfull_blocks: got start_seen=%b tx=%0d want 0 2", seen, bus.tx_count); end
    checks++; if (bus.rd_data !== 8'hC0) begin errors++; $display("FAIL rxfull_head: got %h want c0", bus.rd_data); end
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    wait_start(ok);
    checks++; if (ok !== 1'b1 || bus.m_data_in !== 8'hE1) begin errors++; $display("FAIL rxfull_one_launch: got ok=%b data=%h want 1 e1", ok, bus.m_data_in); end
    respond(8'hC8);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.m_start) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0 || bus.rx_count !== 4'd8 || bus.tx_count !== 4'd1) begin errors++; $display("FAIL rxfull_only_one: got seen=%b rx=%0d tx=%0d want 0 8 1", seen, bus.rx_count, bus.tx_count); end
    checks++; if (bus.rd_data !== 8'hC1) begin errors++; $display("FAIL rxsim_head: got %h want c1", bus.rd_data); end
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    wait_start(ok);
    checks++; if (ok !== 1'b1 || bus.m_data_in !== 8'hE2) begin errors++; $display("FAIL rxsim_launch: got ok=%b data=%h want 1 e2", ok, bus.m_data_in); end
    tick();
    bus.m_data_out = 8'hC9; bus.m_done = 1'b1; bus.rd_en = 1'b1;
    tick();
    bus.m_done = 1'b0; bus.rd_en = 1'b0; bus.run = 1'b0;
    checks++; if (bus.rx_count !== 4'd7 || bus.tx_count !== 4'd0) begin errors++; $display("FAIL rxsim_count: got rx=%0d tx=%0d want 7 0", bus.rx_count, bus.tx_count); end
    for (int i = 0; i < 7; i++) begin
      checks++; if (bus.rd_data !== 8'hC3 + 8'(i)) begin errors++; $display("FAIL drain_%0d: got %h want %h", i, bus.rd_data, 8'hC3 + 8'(i)); end
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
    end
    checks++; if (bus.rx_empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b want 1", bus.rx_empty); end
  endtask

  task automatic test_timeout;
    bit ok;
    bit early;
    int n;
    bus.wr_data = 8'h77; bus.wr_en = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    bus.run = 1'b1;
    wait_start(ok);
    checks++; if (ok !== 1'b1 || bus.m_data_in !== 8'h77) begin errors++; $display("FAIL tmo_launch: got ok=%b data=%h want 1 77", ok, bus.m_data_in); end
    bus.wr_data = 8'h88; bus.wr_en = 1'b1; bus.run = 1'b0;
    tick();
    bus.wr_en = 1'b0;
    n = 1;
    checks++; if (bus.tx_count !== 4'd1) begin errors++; $display("FAIL push_pop_same_edge: got %0d want 1", bus.tx_count); end
    early = 1'b0;
    while (bus.busy && n < 200) begin
      if (bus.tmo_err) early = 1'b1;
      tick();
      n++;
    end
    checks++; if (n !== TIMEOUT + 1 || early !== 1'b0) begin errors++; $display("FAIL tmo_cycles: got edges=%0d early=%b want %0d 0", n, early, TIMEOUT + 1); end
    checks++; if (bus.tmo_err !== 1'b1 || bus.rx_count !== 4'd0 || bus.busy !== 1'b0) begin errors++; $display("FAIL tmo_result: got tmo=%b rx=%0d busy=%b want 1 0 0", bus.tmo_err, bus.rx_count, bus.busy); end
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    checks++; if (bus.tmo_err !== 1'b0) begin errors++; $display("FAIL tmo_clear: got %b want 0", bus.tmo_err); end
  endtask

  task automatic test_underflow;
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    checks++; if (bus.unf_err !== 1'b1 || bus.rx_count !== 4'd0) begin errors++; $display("FAIL unf_set: got unf=%b rx=%0d want 1 0", bus.unf_err, bus.rx_count); end
    bus.rd_en = 1'b1; bus.clr_err = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    checks++; if (bus.unf_err !== 1'b1) begin errors++; $display("FAIL unf_set_beats_clr: got %b want 1", bus.unf_err); end
    tick();
    bus.clr_err = 1'b0;
    checks++; if (bus.unf_err !== 1'b0) begin errors++; $display("FAIL unf_clear: got %b want 0", bus.unf_err); end
  endtask

  task automatic test_reset_in_wait;
    bit ok;
    bus.run = 1'b1;
    wait_start(ok);
    checks++; if (ok !== 1'b1 || bus.m_data_in !== 8'h88) begin errors++; $display("FAIL rstw_launch: got ok=%b data=%h want 1 88", ok, bus.m_data_in); end
    tick();
    bus.run = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rstw_in_wait: got busy=%b want 1", bus.busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.m_data_in !== 8'h00 || bus.tx_count !== 4'd0) begin errors++; $display("FAIL rstw_async: got busy=%b data=%h tx=%0d want 0 00 0", bus.busy, bus.m_data_in, bus.tx_count); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    bus.m_data_out = 8'h55; bus.m_done = 1'b1;
    tick();
    tick();
    bus.m_done = 1'b0;
    checks++; if (bus.rx_count !== 4'd0 || bus.rx_empty !== 1'b1 || bus.tx_count !== 4'd0) begin errors++; $display("FAIL rstw_late_done: got rx=%0d empty=%b tx=%0d want 0 1 0", bus.rx_count, bus.rx_empty, bus.tx_count); end
    checks++; if (bus.m_start !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rstw_idle: got start=%b busy=%b want 0 0", bus.m_start, bus.busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_back_to_back();
    test_timeout();
    test_underflow();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spi_txn_queue.md
SPI_TXN_QUEUE -- requirements
Module: spi_txn_queue

Interface
REQ-001 Parameter: DEPTH, default 8, entries per FIFO (power of two, at least 2); CW = log2(DEPTH)+1.
REQ-002 Parameter: TIMEOUT, default 64, the maximum number of clk cycles to wait for the master done rising edge.
REQ-003 Port: clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-004 Port: rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 Port: wr_en, input, 1, host push into the TX FIFO.
REQ-006 Port: wr_data, input, 8, byte to transmit.
REQ-007 Port: tx_full, output, 1, TX FIFO holds DEPTH entries.
REQ-008 Port: rd_en, input, 1, host pop from the RX FIFO.
REQ-009 Port: rd_data, output, 8, RX FIFO head (first-word fall-through); valid when rx_empty=0.
REQ-010 Port: rx_empty, output, 1, RX FIFO holds 0 entries.
REQ-011 Port: tx_count / rx_count, output, CW each, FIFO occupancies.
REQ-012 Port: run, input, 1, enables launching new transfers.
REQ-013 Port: clr_err, input, 1, clears all sticky error flags.
REQ-014 Port: ovf_err / unf_err / tmo_err, output, 1 each, sticky flags for TX overflow, RX underflow and timeout.
REQ-015 Port: busy, output, 1, high whenever the FSM is not in IDLE.
REQ-016 Port: m_data_in, output, 8, byte presented to the SPI master.
REQ-017 Port: m_start, output, 1, one-cycle start pulse to the SPI master.
REQ-018 Port: m_data_out, input, 8, byte received by the SPI master.
REQ-019 Port: m_done, input, 1, master done level; only its rising edge is meaningful.

Function
REQ-020 Both FIFOs shall be circular buffers with wrapping read/write pointers, and counts shall range 0..DEPTH.
REQ-021 A push with wr_en=1 and tx_full=0 shall store wr_data and increment tx_count on the same edge.
REQ-022 A push while tx_full=1 shall be dropped and shall set ovf_err.
REQ-023 A pop with rd_en=1 and rx_empty=0 shall advance the RX read pointer.
REQ-024 A pop while rx_empty=1 shall be ignored and shall set unf_err.
REQ-025 The FSM shall have three states: IDLE, LAUNCH and WAIT.
REQ-026 IDLE shall go to LAUNCH when run=1, tx_count!=0 and rx_count+inflight<DEPTH; this guarantees space in the RX FIFO for the result.
REQ-027 In LAUNCH the block shall pop the TX head into a holding register driving m_data_in, assert m_start for exactly that cycle, clear the timeout counter, and go to WAIT.
REQ-028 m_data_in shall remain stable from LAUNCH until the block returns to IDLE.
REQ-029 In WAIT, done_rise = m_done AND NOT (m_done registered one cycle earlier).
REQ-030 In WAIT, on done_rise the block shall write m_data_out into the RX FIFO on that edge and go to IDLE.
REQ-031 In WAIT, if TIMEOUT cycles elapse with no done_rise, the block shall set tmo_err, write nothing to the RX FIFO, and go to IDLE; the popped TX byte is discarded.
REQ-032 The minimum back-to-back spacing between consecutive m_start pulses shall be 3 cycles (IDLE, LAUNCH, WAIT).
REQ-033 A simultaneous host push and internal TX pop shall leave tx_count unchanged and keep both operations.
REQ-034 A simultaneous internal RX write and host RX pop shall leave rx_count unchanged and keep both operations.
REQ-035 A push while tx_full=1 shall still be dropped even if the internal TX pop occurs on the same edge.
REQ-036 Deasserting run during WAIT shall not abort the transfer; the transfer shall complete normally.
REQ-037 clr_err shall clear all sticky error flags; if clr_err and a new error event occur on the same edge, the flag shall remain set.
REQ-038 tx_full, rx_empty, the counts and busy shall be combinational decodes of registered state.

Reset
REQ-039 When rst_n=0 (asynchronous), the block shall clear both FIFO pointers and counts, force the FSM to IDLE, and drive m_start=0, m_data_in=8'h00, all error flags=0, busy=0, tx_full=0 and rx_empty=1.
REQ-040 FIFO storage contents shall not be reset.
REQ-041 A reset during WAIT shall abandon the transfer; a late m_done edge arriving after reset shall be ignored while in IDLE.

Verification
REQ-042 Push 8'hA5 with run=1 and respond with m_done rising and m_data_out=8'h3C -> one m_start pulse with m_data_in=8'hA5, then rd_data=8'h3C, rx_count=1, busy=0.
REQ-043 Push 9 bytes with DEPTH=8 and run=0 -> tx_full=1 after the 8th push, and the 9th push sets ovf_err with tx_count staying 8.
REQ-044 With run=1 and no m_done response -> tmo_err=1 after exactly TIMEOUT cycles in WAIT, rx_count=0, and the FSM returns to IDLE.
REQ-045 Fill the RX FIFO with 8 results, with 2 bytes left in TX -> no m_start is issued until one rd_en pop, then exactly one launch follows.
REQ-046 rd_en asserted with rx_empty=1 -> unf_err=1; clr_err pulse -> unf_err=0.
REQ-047 Assert rst_n=0 in WAIT, then release it, with m_done rising afterwards -> no RX write, all counts 0, m_start=0.
